rf_host_config_master: RTL and testbench

//  MCU-side initiator for the RF transceiver's programming interface. It drives M1/M0, monitors AUX
//  and exchanges command/response byte frames (C0/C2/C1/C3[/C4]) through a byte-level UART port.
//  It sits in the host FPGA between the system controller and a com_uart instance in mode-3 format.

---
 rtl/rf_host_config_master.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_rf_host_config_master.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_host_config_master.sv
// rf_host_config_master: drives M1/M0, watches AUX and frames C0/C2/C1/C3 commands over a byte UART.
// Define RF_HOST_RESET_CMD_EN to make op4 (C4 reset command, AUX low-then-high wait) legal.
module rf_host_config_master #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter logic [1:0]  DEFAULT_MODE = 2'd0,
  parameter logic [15:0] AUX_SETTLE   = 16'd1000,
  parameter logic [23:0] AUX_TIMEOUT  = 24'd750000,
  parameter logic [23:0] RX_TIMEOUT   = 24'd50000
) (
  input  logic                  device_clk,
  input  logic                  rst,
  input  logic                  cmd_start,
  input  logic [2:0]            cmd_op,
  input  logic [39:0]           cfg_in,
  input  logic [1:0]            mode_normal,
  output logic                  M0,
  output logic                  M1,
  input  logic                  AUX,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            err_code,
  output logic [47:0]           resp_data
);

  // state | meaning: IDLE wait cmd, SET_M3 program mode, WAIT_A aux ready, SEND frame, RECV response,
  // CHECK compare, RESTORE normal mode + aux ready, DONE pulse, WAIT_LO/WAIT_HI reset-command aux cycle
  typedef enum logic [3:0] {
    S_IDLE, S_SET_M3, S_WAIT_A, S_SEND, S_RECV, S_CHECK, S_RESTORE, S_DONE, S_WAIT_LO, S_WAIT_HI
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [2:0]            err_q, err_d;
  logic [47:0]           resp_q, resp_d;
  logic [2:0]            op_q, op_d;
  logic [39:0]           cfg_q, cfg_d;
  logic [1:0]            mnorm_q, mnorm_d;
  logic [2:0]            idx_q, idx_d;
  logic [2:0]            rx_cnt_q, rx_cnt_d;
  logic [15:0]           settle_q, settle_d;
  logic [23:0]           tmr_q, tmr_d;
  logic                  aux_s1_q, aux_s2_q;
  logic                  tmr_hit, settle_hit, aux_wait, frame_ok;

  function automatic logic op_legal(input logic [2:0] op);
`ifdef RF_HOST_RESET_CMD_EN
    return op <= 3'd4;
`else
    return op <= 3'd3;
`endif
  endfunction

  function automatic logic [7:0] hdr_of(input logic [2:0] op);
    case (op)
      3'd0:    return 8'hC0;
      3'd1:    return 8'hC2;
      3'd2:    return 8'hC1;
      3'd3:    return 8'hC3;
      default: return 8'hC4;
    endcase
  endfunction

  function automatic logic [7:0] frame_byte(input logic [2:0] op, input logic [39:0] cfg,
                                            input logic [2:0] idx);
    if (op > 3'd1) return hdr_of(op);
    case (idx)
      3'd1:    return cfg[39:32];
      3'd2:    return cfg[31:24];
      3'd3:    return cfg[23:16];
      3'd4:    return cfg[15:8];
      3'd5:    return cfg[7:0];
      default: return hdr_of(op);
    endcase
  endfunction

  function automatic logic [2:0] frame_len(input logic [2:0] op);
    return (op <= 3'd1) ? 3'd6 : 3'd3;
  endfunction

  function automatic logic [2:0] rx_len(input logic [2:0] op);
    return (op <= 3'd2) ? 3'd6 : 3'd4;
  endfunction

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    resp_d     = resp_q;
    op_d       = op_q;
    cfg_d      = cfg_q;
    mnorm_d    = mnorm_q;
    idx_d      = idx_q;
    rx_cnt_d   = rx_cnt_q;
    settle_d   = settle_q;
    tmr_d      = tmr_q;
    aux_wait   = 1'b0;
    frame_ok   = 1'b1;
    tmr_hit    = (tmr_q <= 24'd1);
    settle_hit = aux_s2_q && (settle_q <= 16'd1);

    case (state_q)
      S_IDLE: begin
        if (cmd_start) begin
          op_d    = cmd_op;
          cfg_d   = cfg_in;
          mnorm_d = mode_normal;
          busy_d  = 1'b1;
          err_d   = 3'd0;
          resp_d  = 48'd0;
          if (op_legal(cmd_op)) begin
            state_d = S_SET_M3;
          end else begin
            err_d   = 3'd4;
            state_d = S_DONE;
          end
        end
      end
      S_SET_M3: begin
        mode_d  = 2'b11;
        state_d = S_WAIT_A;
      end
      S_WAIT_A: begin
        aux_wait = 1'b1;
        if (settle_hit) begin
          tx_valid_d = 1'b1;
          tx_data_d  = DATA_WIDTH'(frame_byte(op_q, cfg_q, 3'd0));
          idx_d      = 3'd0;
          state_d    = S_SEND;
        end else if (tmr_hit) begin
          if (err_q == 3'd0) err_d = 3'd1;
          state_d = S_RESTORE;
        end
      end
      S_SEND: begin
        if (tx_valid_q && tx_ready) begin
          if (idx_q == frame_len(op_q) - 3'd1) begin
            tx_valid_d = 1'b0;
            rx_cnt_d   = 3'd0;
            state_d    = (op_q == 3'd4) ? S_WAIT_LO : S_RECV;
          end else begin
            idx_d     = idx_q + 3'd1;
            tx_data_d = DATA_WIDTH'(frame_byte(op_q, cfg_q, idx_q + 3'd1));
          end
        end
      end
      S_RECV: begin
        // A byte landing on the expiry cycle still counts and restarts the timer.
        if (rx_valid) begin
          case (rx_cnt_q)
            3'd0:    resp_d[47:40] = rx_data[7:0];
            3'd1:    resp_d[39:32] = rx_data[7:0];
            3'd2:    resp_d[31:24] = rx_data[7:0];
            3'd3:    resp_d[23:16] = rx_data[7:0];
            3'd4:    resp_d[15:8]  = rx_data[7:0];
            default: resp_d[7:0]   = rx_data[7:0];
          endcase
          rx_cnt_d = rx_cnt_q + 3'd1;
          tmr_d    = RX_TIMEOUT;
          if (rx_cnt_q + 3'd1 == rx_len(op_q)) state_d = S_CHECK;
        end else if (tmr_hit) begin
          if (err_q == 3'd0) err_d = 3'd2;
          state_d = S_RESTORE;
        end else begin
          tmr_d = (tmr_q != 24'd0) ? tmr_q - 24'd1 : 24'd0;
        end
      end
      S_CHECK: begin
        case (op_q)
          3'd0, 3'd1: frame_ok = (resp_q == {hdr_of(op_q), cfg_q});
          3'd2:       frame_ok = (resp_q[47:40] == 8'hC0);
          3'd3:       frame_ok = (resp_q[47:40] == 8'hC3);
          default:    frame_ok = 1'b1;
        endcase
        if (!frame_ok && err_q == 3'd0) err_d = 3'd3;
        state_d = S_RESTORE;
      end
      S_RESTORE: begin
        aux_wait = 1'b1;
        if (settle_hit) begin
          state_d = S_DONE;
        end else if (tmr_hit) begin
          if (err_q == 3'd0) err_d = 3'd1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_WAIT_LO: begin
        tmr_d = (tmr_q != 24'd0) ? tmr_q - 24'd1 : 24'd0;
        if (!aux_s2_q) begin
          state_d = S_WAIT_HI;
        end else if (tmr_hit) begin
          if (err_q == 3'd0) err_d = 3'd1;
          state_d = S_RESTORE;
        end
      end
      S_WAIT_HI: begin
        aux_wait = 1'b1;
        if (settle_hit) begin
          state_d = S_RESTORE;
        end else if (tmr_hit) begin
          if (err_q == 3'd0) err_d = 3'd1;
          state_d = S_RESTORE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (aux_wait) begin
      tmr_d    = (tmr_q != 24'd0) ? tmr_q - 24'd1 : 24'd0;
      settle_d = !aux_s2_q ? AUX_SETTLE : ((settle_q != 16'd0) ? settle_q - 16'd1 : 16'd0);
    end

    // Both timers restart on every state entry; entering RESTORE is where the normal mode returns.
    if (state_d != state_q) begin
      settle_d = AUX_SETTLE;
      tmr_d    = (state_d == S_RECV) ? RX_TIMEOUT : AUX_TIMEOUT;
      if (state_d == S_RESTORE) mode_d = mnorm_q;
    end
  end

  always_ff @(posedge device_clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mode_q     <= DEFAULT_MODE;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 3'd0;
      resp_q     <= 48'd0;
      op_q       <= 3'd0;
      cfg_q      <= 40'd0;
      mnorm_q    <= DEFAULT_MODE;
      idx_q      <= 3'd0;
      rx_cnt_q   <= 3'd0;
      settle_q   <= AUX_SETTLE;
      tmr_q      <= AUX_TIMEOUT;
      aux_s1_q   <= 1'b0;
      aux_s2_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      resp_q     <= resp_d;
      op_q       <= op_d;
      cfg_q      <= cfg_d;
      mnorm_q    <= mnorm_d;
      idx_q      <= idx_d;
      rx_cnt_q   <= rx_cnt_d;
      settle_q   <= settle_d;
      tmr_q      <= tmr_d;
      aux_s1_q   <= AUX;
      aux_s2_q   <= aux_s1_q;
    end
  end

  assign M1        = mode_q[1];
  assign M0        = mode_q[0];
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_code  = err_q;
  assign resp_data = resp_q;

endmodule

// File: tb/tb_rf_host_config_master.sv
// Scoreboard bench for rf_host_config_master: a reference model queues expected tx bytes and completions.
module tb_rf_host_config_master;
  localparam int AS = 4;
  localparam int AT = 300;
  localparam int RT = 100;
  localparam logic [1:0] DM = 2'd0;

  logic        device_clk, rst, cmd_start, M0, M1, AUX, tx_valid, tx_ready, rx_valid, busy, done;
  logic [2:0]  cmd_op, err_code;
  logic [39:0] cfg_in;
  logic [1:0]  mode_normal;
  logic [7:0]  tx_data, rx_data;
  logic [47:0] resp_data;

  rf_host_config_master #(
    .DATA_WIDTH(8), .DEFAULT_MODE(DM), .AUX_SETTLE(16'(AS)),
    .AUX_TIMEOUT(24'(AT)), .RX_TIMEOUT(24'(RT))
  ) dut (
    .device_clk(device_clk), .rst(rst), .cmd_start(cmd_start), .cmd_op(cmd_op), .cfg_in(cfg_in),
    .mode_normal(mode_normal), .M0(M0), .M1(M1), .AUX(AUX), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done),
    .err_code(err_code), .resp_data(resp_data)
  );

  initial device_clk = 1'b0;
  always #5 device_clk = ~device_clk;

  int cyc = 0;
  always @(posedge device_clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  err;
    logic [47:0] resp;
    logic [1:0]  m;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] exp_tx[$];
  logic [7:0] drv_q[$];
  int tests = 0, fails = 0;
  int hs_cnt = 0, done_cnt = 0, done_cyc = 0, last_rx_cyc = 0;
  logic hold_ready = 1'b0;
  logic [1:0] model_m = DM;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge device_clk);
    #1;
  endtask

  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge device_clk);
      #1;
      tx_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: tx handshakes, tx hold stability and completions, all sampled on the falling edge.
  initial begin
    logic       prev_v, prev_r;
    logic [7:0] prev_d;
    exp_t       e;
    prev_v = 1'b0; prev_r = 1'b0; prev_d = 8'd0;
    forever begin
      @(negedge device_clk);
      if (!rst) begin
        if (tx_valid && tx_ready) begin
          hs_cnt++;
          if (exp_tx.size() == 0) begin
            tests++; fails++;
            $display("FAIL tx_unexpected: got %0h expected no byte", tx_data);
          end else chk("tx_byte", 64'(tx_data), 64'(exp_tx.pop_front()));
        end
        if (prev_v && !prev_r) begin
          chk("tx_hold_valid", 64'(tx_valid), 64'd1);
          chk("tx_hold_data", 64'(tx_data), 64'(prev_d));
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL done_unexpected: got done=1 expected none");
          end else begin
            e = exp_q.pop_front();
            chk("err_code", 64'(err_code), 64'(e.err));
            chk("resp_data", 64'(resp_data), 64'(e.resp));
            chk("m_pins", 64'({M1, M0}), 64'(e.m));
            chk("busy_at_done", 64'(busy), 64'd0);
          end
        end
      end
      prev_v = tx_valid; prev_r = tx_ready; prev_d = tx_data;
    end
  end

  function automatic logic [7:0] hdr(input logic [2:0] op);
    case (op)
      3'd0: return 8'hC0;
      3'd1: return 8'hC2;
      3'd2: return 8'hC1;
      3'd3: return 8'hC3;
      default: return 8'hC4;
    endcase
  endfunction

  function automatic bit legal(input logic [2:0] op);
`ifdef RF_HOST_RESET_CMD_EN
    return op <= 3'd4;
`else
    return op <= 3'd3;
`endif
  endfunction

  // Model a command from the protocol rules, queue expectations, then play transceiver with drv_q.
  task automatic issue(input logic [2:0] op, input logic [39:0] cfg, input logic [1:0] mn);
    logic [7:0]  frame[$];
    logic [7:0]  got[$];
    logic [47:0] resp;
    logic [2:0]  err;
    int          rxn, hs_base, d0, n;
    exp_t        e;
    rxn = (op <= 3'd2) ? 6 : (op == 3'd3) ? 4 : 0;
    if (op <= 3'd1) begin
      frame.push_back(hdr(op));
      for (int i = 4; i >= 0; i--) frame.push_back(cfg[8*i +: 8]);
    end else begin
      for (int i = 0; i < 3; i++) frame.push_back(hdr(op));
    end
    for (int i = 0; i < drv_q.size() && i < rxn; i++) got.push_back(drv_q[i]);
    resp = 48'd0;
    for (int i = 0; i < got.size(); i++) resp[47-8*i -: 8] = got[i];
    if (!legal(op)) begin
      err = 3'd4; resp = 48'd0;
    end else if (got.size() < rxn) begin
      err = 3'd2;
    end else if (op <= 3'd1) begin
      err = 3'd0;
      for (int i = 0; i < 6; i++) if (got[i] != frame[i]) err = 3'd3;
    end else if (op == 3'd2) begin
      err = (got[0] == 8'hC0) ? 3'd0 : 3'd3;
    end else if (op == 3'd3) begin
      err = (got[0] == 8'hC3) ? 3'd0 : 3'd3;
    end else begin
      err = 3'd0;
    end
    if (legal(op)) begin
      foreach (frame[i]) exp_tx.push_back(frame[i]);
      model_m = mn;
    end
    e.err = err; e.resp = resp; e.m = model_m;
    exp_q.push_back(e);

    hs_base = hs_cnt;
    d0 = done_cnt;
    cmd_op = op; cfg_in = cfg; mode_normal = mn; cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    if (legal(op)) begin
      n = 0;
      while (hs_cnt < hs_base + frame.size() && n < 3000) begin tick(); n++; end
      if (hs_cnt < hs_base + frame.size()) begin
        tests++; fails++;
        $display("FAIL tx_frame_wait: got %0d bytes expected %0d", hs_cnt - hs_base, frame.size());
      end
      if (op == 3'd4) begin
        AUX = 1'b0;
        repeat (6) tick();
        AUX = 1'b1;
      end
      foreach (drv_q[i]) begin
        repeat ($urandom_range(1, 4)) tick();
        rx_data = drv_q[i]; rx_valid = 1'b1; last_rx_cyc = cyc;
        tick();
        rx_valid = 1'b0;
      end
    end
    n = 0;
    while (done_cnt == d0 && n < 5000) begin tick(); n++; end
    if (done_cnt == d0) begin
      tests++; fails++;
      $display("FAIL done_wait: got no done expected done within 5000 cycles");
    end
    repeat (2) tick();
  endtask

  task automatic wait_tx_valid();
    int n = 0;
    while (!tx_valid && n < 2000) begin tick(); n++; end
    chk("tx_valid_seen", 64'(tx_valid), 64'd1);
  endtask

  initial begin
    int d0, t0, lat, h0, r, n;
    logic [39:0] cfg;
    logic [2:0]  op;
    rst = 1'b1; cmd_start = 1'b0; cmd_op = 3'd0; cfg_in = 40'd0; mode_normal = DM;
    AUX = 1'b1; rx_valid = 1'b0; rx_data = 8'd0;
    repeat (3) tick();
    chk("rst_m", 64'({M1, M0}), 64'(DM));
    chk("rst_tx_valid", 64'(tx_valid), 64'd0);
    chk("rst_tx_data", 64'(tx_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err_code), 64'd0);
    chk("rst_resp", 64'(resp_data), 64'd0);
    rst = 1'b0;
    repeat (3) tick();

    // Read cfg with echo, mode pins must be 11 while framing.
    drv_q = '{8'hC0, 8'h12, 8'h34, 8'h1A, 8'h17, 8'h44};
    d0 = done_cnt;
    fork
      issue(3'd2, 40'h0, 2'b00);
      begin wait_tx_valid(); chk("m_during_cmd", 64'({M1, M0}), 64'd3); end
    join
    chk("t1_resp", 64'(resp_data), 64'h0000C012341A1744);
    chk("t1_done_pulses", 64'(done_cnt - d0), 64'd1);

    drv_q = '{8'hC0, 8'h00, 8'h01, 8'h1A, 8'h17, 8'h44};
    issue(3'd0, 40'h00011A1744, 2'b00);
    chk("t2_err_ok", 64'(err_code), 64'd0);
    drv_q = '{8'hC0, 8'h00, 8'h01, 8'hFF, 8'h17, 8'h44};
    issue(3'd0, 40'h00011A1744, 2'b00);
    chk("t2_err_corrupt", 64'(err_code), 64'd3);

    drv_q = '{8'hC3, 8'h32, 8'h27, 8'h02};
    issue(3'd3, 40'h0, 2'b01);
    chk("t3_resp", 64'(resp_data), 64'h0000C33227020000);

    // AUX stuck low: WAIT_A and RESTORE both run out, first error is kept.
    AUX = 1'b0;
    repeat (3) tick();
    model_m = 2'b10;
    exp_q.push_back('{err: 3'd1, resp: 48'd0, m: 2'b10});
    d0 = done_cnt;
    cmd_op = 3'd2; mode_normal = 2'b10; cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0; t0 = cyc;
    n = 0;
    while (done_cnt == d0 && n < 2 * AT + 100) begin tick(); n++; end
    lat = done_cyc - t0;
    chk("t4_done_seen", 64'(done_cnt - d0), 64'd1);
    chk("t4_latency_in_range", 64'(lat >= 2 * AT && lat <= 2 * AT + 10), 64'd1);
    AUX = 1'b1;
    repeat (4) tick();

    drv_q = '{8'hC0, 8'hAA};
    issue(3'd2, 40'h0, 2'b00);
    lat = done_cyc - last_rx_cyc;
    chk("t5_rx_timeout_latency", 64'(lat >= RT && lat <= RT + AS + 10), 64'd1);

    hold_ready = 1'b1;
    tick();
    cfg = {$urandom(), 8'($urandom())};
    drv_q = '{8'hC2, cfg[39:32], cfg[31:24], cfg[23:16], cfg[15:8], cfg[7:0]};
    fork
      issue(3'd1, cfg, 2'b01);
      begin
        wait_tx_valid();
        h0 = hs_cnt;
        repeat (20) tick();
        chk("t5_stall_no_handshake", 64'(hs_cnt), 64'(h0));
        chk("t5_stall_valid_held", 64'(tx_valid), 64'd1);
        hold_ready = 1'b0;
      end
    join

    // Reset while a byte is held in SEND.
    hold_ready = 1'b1;
    tick();
    cmd_op = 3'd1; cfg_in = 40'h55; mode_normal = 2'b01; cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    wait_tx_valid();
    tick();
    rst = 1'b1;
    @(posedge device_clk);
    @(negedge device_clk);
    chk("t6_rst_m", 64'({M1, M0}), 64'(DM));
    chk("t6_rst_tx_valid", 64'(tx_valid), 64'd0);
    chk("t6_rst_tx_data", 64'(tx_data), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_done", 64'(done), 64'd0);
    chk("t6_rst_err", 64'(err_code), 64'd0);
    chk("t6_rst_resp", 64'(resp_data), 64'd0);
    tick();
    rst = 1'b0; hold_ready = 1'b0; model_m = DM;
    repeat (4) tick();

    // cmd_start while busy must be ignored.
    drv_q = '{8'hC0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    fork
      issue(3'd2, 40'h0, 2'b00);
      begin
        repeat (6) tick();
        cmd_op = 3'd0; cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
      end
    join

    drv_q.delete();
    issue(3'd4, 40'h0, 2'b11);

    for (int it = 0; it < 30; it++) begin
      r = $urandom_range(0, 11);
      op = (r < 10) ? 3'(r % 4) : 3'($urandom_range(4, 7));
      cfg = {$urandom(), 8'($urandom())};
      drv_q.delete();
      if (op <= 3'd1) begin
        drv_q.push_back(hdr(op));
        for (int i = 4; i >= 0; i--) drv_q.push_back(cfg[8*i +: 8]);
      end else if (op == 3'd2) begin
        drv_q.push_back(8'hC0);
        for (int i = 0; i < 5; i++) drv_q.push_back(8'($urandom()));
      end else if (op == 3'd3) begin
        drv_q.push_back(8'hC3);
        for (int i = 0; i < 3; i++) drv_q.push_back(8'($urandom()));
      end
      if (drv_q.size() > 0) begin
        r = $urandom_range(0, 9);
        if (r < 3) begin
          n = $urandom_range(0, drv_q.size() - 1);
          drv_q[n] = drv_q[n] ^ 8'($urandom_range(1, 255));
        end else if (r == 3) begin
          void'(drv_q.pop_back());
        end else if (r < 6) begin
          drv_q.push_back(8'($urandom()));
        end
      end
      if ($urandom_range(0, 2) == 0) begin
        rx_data = 8'($urandom()); rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
      end
      issue(op, cfg, 2'($urandom_range(0, 3)));
    end

    repeat (5) tick();
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("exp_tx_drained", 64'(exp_tx.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
